// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 scheduler slice: scheduler states, stage identifiers
// and the default S-RAM geometry.
package arc4_pkg;

  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_DATA_W = 8;

  typedef enum logic [2:0] {
    SCHED_IDLE       = 3'd0,
    SCHED_INIT_START = 3'd1,
    SCHED_INIT_RUN   = 3'd2,
    SCHED_KSA_START  = 3'd3,
    SCHED_KSA_RUN    = 3'd4,
    SCHED_PRGA_START = 3'd5,
    SCHED_PRGA_RUN   = 3'd6,
    SCHED_ERR        = 3'd7
  } sched_state_t;

  typedef enum logic [1:0] {
    STAGE_NONE = 2'd0,
    STAGE_INIT = 2'd1,
    STAGE_KSA  = 2'd2,
    STAGE_PRGA = 2'd3
  } stage_t;

  // The stage that owns the S-RAM port in a given scheduler state.
  function automatic stage_t owner_of(input logic [2:0] st);
    stage_t owner;
    owner = STAGE_NONE;
    case (sched_state_t'(st))
      SCHED_INIT_START, SCHED_INIT_RUN: owner = STAGE_INIT;
      SCHED_KSA_START,  SCHED_KSA_RUN:  owner = STAGE_KSA;
      SCHED_PRGA_START, SCHED_PRGA_RUN: owner = STAGE_PRGA;
      default:                          owner = STAGE_NONE;
    endcase
    return owner;
  endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Combinational 3:1 selector for a shared single-port S-RAM; any stage that is
// not selected has its address, data and write enable dropped.
module sram_port_mux
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
) (
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_din,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_din,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_din,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren
);

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_wren = 1'b0;
    case (stage_t'(sel))
      STAGE_INIT: begin
        ram_addr = init_addr;
        ram_din  = init_din;
        ram_wren = init_wren;
      end
      STAGE_KSA: begin
        ram_addr = ksa_addr;
        ram_din  = ksa_din;
        ram_wren = ksa_wren;
      end
      STAGE_PRGA: begin
        ram_addr = prga_addr;
        ram_din  = prga_din;
        ram_wren = prga_wren;
      end
      default: begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: walks init -> ksa -> prga over the rdy/en handshake,
// hands the single S-RAM port to the active stage and guards each stage with a watchdog.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int ADDR_W        = ARC4_ADDR_W,
  parameter int DATA_W        = ARC4_DATA_W,
  parameter int STAGE_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic              err,
  output logic [1:0]        stage,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_din,
  input  logic [DATA_W-1:0] ksa_din,
  input  logic [DATA_W-1:0] prga_din,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren
);

  localparam logic [2:0] ST_IDLE       = SCHED_IDLE;
  localparam logic [2:0] ST_INIT_START = SCHED_INIT_START;
  localparam logic [2:0] ST_INIT_RUN   = SCHED_INIT_RUN;
  localparam logic [2:0] ST_KSA_START  = SCHED_KSA_START;
  localparam logic [2:0] ST_KSA_RUN    = SCHED_KSA_RUN;
  localparam logic [2:0] ST_PRGA_START = SCHED_PRGA_START;
  localparam logic [2:0] ST_PRGA_RUN   = SCHED_PRGA_RUN;
  localparam logic [2:0] ST_ERR        = SCHED_ERR;

  // A zero timeout still needs a legal one-bit counter even though it never fires.
  localparam int WD_W = (STAGE_TIMEOUT > 0) ? $clog2(STAGE_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = '1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((STAGE_TIMEOUT > 0) ? STAGE_TIMEOUT - 1 : 0);

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic [WD_W-1:0] wd_cnt;
  logic            in_stage;
  logic            wd_expired;
  logic [1:0]      owner;

  always_comb begin
    in_stage   = (state != ST_IDLE) && (state != ST_ERR);
    wd_expired = (STAGE_TIMEOUT != 0) && in_stage && (wd_cnt == WD_LIMIT);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (en)        state_next = ST_INIT_START;
      ST_INIT_START: if (!init_rdy) state_next = ST_INIT_RUN;
      ST_INIT_RUN:   if (init_rdy)  state_next = ST_KSA_START;
      ST_KSA_START:  if (!ksa_rdy)  state_next = ST_KSA_RUN;
      ST_KSA_RUN:    if (ksa_rdy)   state_next = ST_PRGA_START;
      ST_PRGA_START: if (!prga_rdy) state_next = ST_PRGA_RUN;
      ST_PRGA_RUN:   if (prga_rdy)  state_next = ST_IDLE;
      ST_ERR:        if (en)        state_next = ST_INIT_START;
      default:                      state_next = ST_IDLE;
    endcase
    // An expired watchdog wins over any handshake progress in the same cycle.
    if (wd_expired) state_next = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counts cycles spent in the current state; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state_next != state) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_comb begin
    owner   = owner_of(state);
    stage   = owner;
    rdy     = (state == ST_IDLE) || (state == ST_ERR);
    err     = (state == ST_ERR);
    init_en = (state == ST_INIT_START);
    ksa_en  = (state == ST_KSA_START);
    prga_en = (state == ST_PRGA_START);
  end

  sram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .sel       (owner),
    .init_addr (init_addr),
    .init_din  (init_din),
    .init_wren (init_wren),
    .ksa_addr  (ksa_addr),
    .ksa_din   (ksa_din),
    .ksa_wren  (ksa_wren),
    .prga_addr (prga_addr),
    .prga_din  (prga_din),
    .prga_wren (prga_wren),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wren  (ram_wren)
  );

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for the ARC4 datapath: runs init → ksa → prga over the rdy/en handshake and owns the single-port S-RAM.
- Muxes the one S-RAM port (addr/din/wren) to the currently active stage, so exactly one stage drives the RAM at a time.
- Adds a per-stage watchdog and a sticky error flag.
- Sits between the top-level controller (or testbench) and the three stage modules plus the bram instance.

Parameters:
ADDR_W, 8, S-RAM address width
DATA_W, 8, S-RAM data width
STAGE_TIMEOUT, 65535, max cycles allowed in any one START or RUN state; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  start request; accepted only when rdy=1
rdy  out  1  scheduler idle (IDLE or ERR)
err  out  1  sticky watchdog error
stage  out  2  0=none, 1=init, 2=ksa, 3=prga
init_en / ksa_en / prga_en  out  1 each  stage start requests
init_rdy / ksa_rdy / prga_rdy  in  1 each  stage idle flags
init_addr / ksa_addr / prga_addr  in  ADDR_W each  stage RAM addresses
init_din / ksa_din / prga_din  in  DATA_W each  stage write data
init_wren / ksa_wren / prga_wren  in  1 each  stage write enables
ram_addr  out  ADDR_W  to bram
ram_din  out  DATA_W  to bram
ram_wren  out  1  to bram
(ram_dout fans out from bram to all stages directly; not routed through this block.)

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst); the clock and reset ports are named clk and rst.
- FSM states: IDLE, INIT_START, INIT_RUN, KSA_START, KSA_RUN, PRGA_START, PRGA_RUN, ERR.
- All outputs are Moore decodes of the registered state.
- Reset:
  - state=IDLE, watchdog=0.
  - Outputs after the reset edge: rdy=1, err=0, stage=0, all x_en=0, ram_addr=0, ram_din=0, ram_wren=0.
  - rst mid-operation aborts immediately. Stages are not reset by this block.
- IDLE:
  - en=1 at edge N → INIT_START; init_en=1 from cycle N+1.
  - en=0 → stay.
- X_START:
  - x_en=1.
  - x_rdy=0 sampled → X_RUN, with x_en=0 on the next cycle.
  - A stage already busy when entered is held here until its rdy drops after it has seen en.
- X_RUN:
  - x_en=0.
  - x_rdy=1 sampled → next stage's START (INIT→KSA→PRGA); PRGA_RUN → IDLE.
- en is ignored in every state except IDLE and ERR.
- ERR:
  - rdy=1, err=1, all x_en=0.
  - en=1 → INIT_START and clears err on that edge.
- Watchdog:
  - Counter clears on every state change and increments each cycle otherwise.
  - If STAGE_TIMEOUT≠0 and count reaches STAGE_TIMEOUT-1 while in a START/RUN state, the next state is ERR.
  - Width: clog2(STAGE_TIMEOUT+1); saturates, never wraps.
- RAM mux:
  - Owner is init in INIT_*, ksa in KSA_*, prga in PRGA_*, none in IDLE/ERR.
  - ram_* is the owner's signals, combinational from registered state, zero added latency.
  - Owner none → ram_addr=0, ram_din=0, ram_wren=0.
  - Non-owner wren is discarded.
- Handoff: in the cycle after X_RUN→next START, ownership switches. The completed stage's outputs are already don't-care, so there are no cross-stage writes.
- stage: 1/2/3 during the matching START/RUN states, 0 otherwise.
- Minimum sequence latency: en edge → rdy back high is ≥ 6 cycles plus stage run times.

Decomposition:
- arc4_pkg holds:
  - sched_state_t enum (8 states)
  - stage_t enum (NONE, INIT, KSA, PRGA)
  - ADDR_W/DATA_W defaults
- One sub-module, sram_port_mux: pure combinational 3:1 mux indexed by stage_t, zero output on NONE. It is reusable by any future S-RAM sharer.

Test Plan:
1. Nominal run, stub stages with 10/20/30 busy cycles:
   - rst pulse then en=1 for one cycle → init_en, ksa_en, prga_en each high until the matching rdy falls.
   - stage goes 1→2→3→0; rdy=1 again after PRGA_RUN; err=0.
2. RAM ownership:
   - init drives addr=0x11/wren=1, ksa drives 0x22/wren=1, prga 0x33/wren=1, concurrently.
   - ram_addr=0x11 in INIT_*, 0x22 in KSA_*, 0x33 in PRGA_*; ram_wren=0 and ram_addr=0 in IDLE.
3. Real datapath: real init plus bram, with stub ksa/prga completing immediately → after rdy=1, S[i]=i for all 256 addresses.
4. Watchdog, STAGE_TIMEOUT=50: ksa_rdy held 0 forever → ERR exactly 50 cycles after entering KSA_RUN; err=1, rdy=1, ksa_en=0, ram_wren=0. A following en=1 → err=0 and init_en=1.
5. Ignored start: en=1 held for the whole of a run → no restart mid-sequence; a new sequence begins on the IDLE cycle where en=1 is sampled.
6. Reset mid-KSA: assert rst during KSA_RUN → the next cycle has state IDLE, ksa_en=0, stage=0, ram_wren=0, rdy=1.
